// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, WIDTH cycles.
// Define SERIAL_SUB_FLAGS_EN to add the registered zero/lt result flags.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             lt
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rd;
    logic [CW-1:0]    cnt;
    logic             brw;

    logic             accept;
    logic             step;
    logic             last;
    logic             a0;
    logic             b0;
    logic             d;
    logic             brw_n;
    logic [WIDTH-1:0] rd_n;

    assign a0    = ra[0];
    assign b0    = rb[0];
    assign d     = a0 ^ b0 ^ brw;
    assign brw_n = (~a0 & b0) | (~(a0 ^ b0) & brw);
    assign rd_n  = {d, rd[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Counter is cleared on the final bit so it never wraps inside RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            rd   <= '0;
            cnt  <= '0;
            brw  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n == RUN);
            done <= (state_n == DONE);
            if (accept) begin
                ra  <= a;
                rb  <= b;
                brw <= 1'b0;
                cnt <= '0;
            end else if (step) begin
                ra  <= ra >> 1;
                rb  <= rb >> 1;
                rd  <= rd_n;
                brw <= brw_n;
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    assign diff = rd;
    assign bout = brw;

`ifdef SERIAL_SUB_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero <= 1'b0;
            lt   <= 1'b0;
        end else if (last) begin
            zero <= (rd_n == '0);
            lt   <= brw_n;
        end
    end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8 directed/random,
// WIDTH=4 exhaustive sweep) against an arithmetic reference model.
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;

`ifdef SERIAL_SUB_FLAGS_EN
    logic       zero8;
    logic       lt8;
    logic       zero4;
    logic       lt4;
`endif

    int total;
    int bad;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero  (zero8),
        .lt    (lt8)
`endif
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero  (zero4),
        .lt    (lt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full WIDTH=8 transaction with cycle-exact busy/done checks.
    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input bit poke);
        logic [7:0] ed;
        logic       eb;
        ed = 8'(x - y);
        eb = (x < y);
        @(negedge clk);
        start8 = 1'b1;
        a8 = x;
        b8 = y;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", {31'd0, busy8}, 32'd1);
            chk("done_run", {31'd0, done8}, 32'd0);
            if (poke && i == 3) begin
                start8 = 1'b1;
                a8 = 8'h01;
                b8 = 8'h02;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, done8}, 32'd1);
        chk("busy_done", {31'd0, busy8}, 32'd0);
        chk("diff8", {24'd0, diff8}, {24'd0, ed});
        chk("bout8", {31'd0, bout8}, {31'd0, eb});
`ifdef SERIAL_SUB_FLAGS_EN
        chk("zero8", {31'd0, zero8}, {31'd0, (ed == 8'd0)});
        chk("lt8", {31'd0, lt8}, {31'd0, eb});
`endif
        @(negedge clk);
        chk("done_low", {31'd0, done8}, 32'd0);
        chk("busy_idle", {31'd0, busy8}, 32'd0);
        chk("diff_hold", {24'd0, diff8}, {24'd0, ed});
        chk("bout_hold", {31'd0, bout8}, {31'd0, eb});
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y);
        int n;
        @(negedge clk);
        start4 = 1'b1;
        a4 = x;
        b4 = y;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("lat4", n, 32'd4);
        chk("diff4", {28'd0, diff4}, {28'd0, 4'(x - y)});
        chk("bout4", {31'd0, bout4}, {31'd0, (x < y)});
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start8 = 1'b1;
        a8     = 8'hA5;
        b8     = 8'h11;
        start4 = 1'b1;
        a4     = 4'h3;
        b4     = 4'h1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_bout", {31'd0, bout8}, 32'd0);
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        start8 = 1'b0;
        start4 = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("idle_hold", {31'd0, busy8}, 32'd0);

        op8(8'h5A, 8'h3C, 1'b0);
        op8(8'h00, 8'h01, 1'b0);
        op8(8'h7F, 8'h7F, 1'b0);
        op8(8'hFF, 8'h00, 1'b0);
        op8(8'h80, 8'hFF, 1'b1);

        // Abort on the 4th RUN cycle; no done may follow.
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'hC3;
        b8 = 8'h2D;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_diff", {24'd0, diff8}, 32'd0);
        chk("abort_bout", {31'd0, bout8}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_nodone", {31'd0, done8}, 32'd0);
        end
        op8(8'h10, 8'h01, 1'b0);

        // start sampled together with reset is discarded.
        @(negedge clk);
        rst_n = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start8 = 1'b0;
        @(negedge clk);
        chk("rst_start_drop", {31'd0, busy8}, 32'd0);

        for (int k = 0; k < 30; k++) begin
            op8(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                op4(4'(x), 4'(y));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
